// File: rtl/pass_check.sv
// pass_check: keypad entry and password comparison stage feeding dealPass.
// Collects BCD digit keys into a buffer and compares it with the stored
// password on Enter. Change (while unlocked) enters a new password.
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous active-low reset
//   key_valid  one-cycle key strobe, key_code valid in the same cycle
//   key_code   0-9 digit, A Clear, B Enter, C Change, D-F ignored
//   lock       from dealPass; while high all keys are ignored and entry is flushed
//   unlock     from dealPass; qualifies the Change key
//   right      one-cycle pulse on a matching entry or a completed password change
//   error      one-cycle pulse on a mismatching or short entry
//   digit_cnt  number of digits currently buffered
//   set_mode   high while a new password is being entered
module pass_check #(
  parameter int unsigned             PASS_LEN     = 4,
  parameter logic [4*PASS_LEN-1:0]   DEFAULT_PASS = 16'h1234,
  parameter int unsigned             TIMEOUT      = 500
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  input  logic       lock,
  input  logic       unlock,
  output logic       right,
  output logic       error,
  output logic [3:0] digit_cnt,
  output logic       set_mode
);

  localparam int unsigned W  = 4 * PASS_LEN;
  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [3:0]    FULL_CNT = 4'(PASS_LEN);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT - 1);

  localparam logic [3:0] KEY_CLEAR  = 4'hA;
  localparam logic [3:0] KEY_ENTER  = 4'hB;
  localparam logic [3:0] KEY_CHANGE = 4'hC;

  typedef enum logic [1:0] {
    IDLE,
    ENTRY,
    SET
  } state_t;

  state_t        state;
  logic [W-1:0]  digit_buf;
  logic [W-1:0]  stored;
  logic [TW-1:0] idle_cnt;

  logic key_ok;
  logic is_digit;
  logic full;

  // Codes D-F are not keys at all: they neither act nor restart the idle timer.
  always_comb begin
    key_ok   = key_valid && !lock && (key_code <= KEY_CHANGE);
    is_digit = key_code <= 4'd9;
    full     = digit_cnt == FULL_CNT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      digit_buf <= '0;
      stored    <= DEFAULT_PASS;
      idle_cnt  <= '0;
      digit_cnt <= '0;
      right     <= 1'b0;
      error     <= 1'b0;
      set_mode  <= 1'b0;
    end else begin
      right <= 1'b0;
      error <= 1'b0;
      if (lock) begin
        state     <= IDLE;
        digit_buf <= '0;
        digit_cnt <= '0;
        idle_cnt  <= '0;
        set_mode  <= 1'b0;
      end else if (key_ok) begin
        idle_cnt <= '0;
        if (is_digit) begin
          // A full buffer drops further digits; the count saturates.
          if (!full) begin
            digit_buf <= {digit_buf[W-5:0], key_code};
            digit_cnt <= digit_cnt + 4'd1;
            if (state == IDLE) state <= ENTRY;
          end
        end else if (key_code == KEY_CLEAR) begin
          state     <= IDLE;
          digit_buf <= '0;
          digit_cnt <= '0;
          set_mode  <= 1'b0;
        end else if (key_code == KEY_ENTER) begin
          if (state == SET) begin
            if (full) begin
              stored <= digit_buf;
              right  <= 1'b1;
            end else begin
              error  <= 1'b1;
            end
          end else if (full && digit_buf == stored) begin
            right <= 1'b1;
          end else begin
            error <= 1'b1;
          end
          state     <= IDLE;
          digit_buf <= '0;
          digit_cnt <= '0;
          set_mode  <= 1'b0;
        end else begin
          if (state == IDLE && unlock) begin
            state    <= SET;
            set_mode <= 1'b1;
          end
        end
      end else if (state != IDLE) begin
        if (idle_cnt == TO_LAST) begin
          state     <= IDLE;
          digit_buf <= '0;
          digit_cnt <= '0;
          idle_cnt  <= '0;
          set_mode  <= 1'b0;
        end else begin
          idle_cnt <= idle_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/pass_check.md
# pass_check

Keypad-entry and comparison stage that sits directly upstream of `dealPass`. It collects decoded key presses into a digit buffer and compares the buffer against a stored password when Enter is pressed. It issues single-cycle `right`/`error` pulses that `dealPass` consumes to drive `lock`, `unlock` and `beef`. It also supports changing the password while the door is unlocked.

## Interface
- `PASS_LEN`, 4: number of BCD digits in the password (2..8).
- `DEFAULT_PASS`, 16'h1234: reset value of the stored password, `4*PASS_LEN` bits, most significant digit entered first.
- `TIMEOUT`, 500: idle cycles allowed in the middle of an entry before the buffer is silently discarded.
- `clk` input, 1 bit: system clock, rising edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `key_valid` input, 1 bit: one-cycle strobe; `key_code` is valid in the same cycle.
- `key_code` input, 4 bits: values 0–9 are digits, 4'hA is Clear, 4'hB is Enter, 4'hC is Change. Values 4'hD–4'hF are ignored.
- `lock` input, 1 bit: from `dealPass`. While it is high, all keys are ignored.
- `unlock` input, 1 bit: from `dealPass`. It qualifies the Change key.
- `right` output, 1 bit: one-cycle pulse when the entry matches.
- `error` output, 1 bit: one-cycle pulse when the entry mismatches or is short.
- `digit_cnt` output, 4 bits: number of digits currently buffered, for the display.
- `set_mode` output, 1 bit: high while a new password is being entered.

## Operation
- States:
  - IDLE: buffer empty.
  - ENTRY: 1..PASS_LEN digits buffered.
  - SET: new-password entry.
- Digit key:
  - Shift the digit into the buffer as `buf <= {buf[4*PASS_LEN-5:0], key}` and increment `digit_cnt`.
  - A digit in IDLE moves the FSM to ENTRY.
  - Digits arriving once `digit_cnt == PASS_LEN` are dropped; the count saturates.
- Clear key: empties the buffer and sets `digit_cnt` to 0. From ENTRY, go to IDLE. From SET, abort to IDLE; the stored password is unchanged.
- Enter key in IDLE or ENTRY:
  - If `digit_cnt == PASS_LEN` and `buf == stored`, pulse `right`.
  - Otherwise pulse `error`. Enter in IDLE with 0 digits also pulses `error`.
  - In either case, clear the buffer and go to IDLE.
- Change key:
  - Accepted only in IDLE with `unlock == 1`: go to SET and raise `set_mode`.
  - Ignored in every other case.
- Enter key in SET:
  - With exactly PASS_LEN digits: load `stored <= buf`, pulse `right`, go to IDLE.
  - With a short entry: pulse `error`, keep the old password, go to IDLE.
- Timeout:
  - An idle counter is cleared on every accepted key and counts only in ENTRY or SET.
  - When it reaches TIMEOUT, clear the buffer and go to IDLE with no pulse.
- `lock` high:
  - Clear the buffer, force IDLE and drop `set_mode` on the next clock.
  - `key_valid` is ignored while `lock` is high.
- `right` and `error` are never high in the same cycle.
- `stored` is only changed by reset or by a completed SET.

## Timing
- Reset, asynchronous on `rst == 0`:
  - State goes to IDLE; `buf`, `digit_cnt` and the idle counter go to 0; `stored` goes to DEFAULT_PASS.
  - `right`, `error` and `set_mode` go to 0.
  - Reset in the middle of an entry or in SET discards it, and any password set earlier reverts to DEFAULT_PASS.
- Latency:
  - A key strobe at edge N updates `digit_cnt` and `set_mode` at edge N+1.
  - Enter at edge N produces `right` or `error` high for exactly the cycle N+1..N+2.
- Back-to-back strobes on every cycle are supported; each one is processed.
- `key_valid` together with `lock` rising in the same cycle: `lock` wins and the key is dropped.
- Timeout fires on the cycle when the idle counter equals TIMEOUT−1 and no key arrives. A key strobe in that same cycle wins and resets the counter.
- All outputs are registered; no combinational path runs from inputs to outputs.

## Test plan
- Reset, then keys 1,2,3,4,Enter:
  - `digit_cnt` steps 1→4.
  - `right` pulses for one cycle one clock after Enter.
  - `digit_cnt` returns to 0.
- Keys 1,2,3,5,Enter → a single `error` pulse and no `right`. Keys 1,2,Enter → `error` (short entry).
- Keys 1,2,3,4,9,Enter → the fifth digit is dropped, `digit_cnt` stays at 4, and `right` pulses. Keys 1,2,Clear,3,4,Enter → `error`.
- Change password:
  - With `unlock = 1`: Change, then 5,6,7,8,Enter → `set_mode` is high during entry, then `right` pulses.
  - Afterwards 1,2,3,4,Enter → `error`, and 5,6,7,8,Enter → `right`.
  - Change pressed with `unlock = 0` → `set_mode` stays 0.
- Keys 1,2 followed by TIMEOUT idle cycles → `digit_cnt` goes to 0 with no pulse. With `lock = 1`, keys 1,2,3,4,Enter → no pulse and `digit_cnt` stays 0.
- Recovery from reset in SET: after a password change to 5678, assert `rst = 0` in the middle of the next entry, then release it. Expected: all outputs are 0, and 1,2,3,4,Enter gives `right`.
